// File: rtl/arith_pkg.sv
// arith_pkg: shared widths, iteration count and multiplier state type for the arithmetic datapath.
package arith_pkg;
    localparam int WORD_W   = 32;
    localparam int PROD_W   = 64;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/add.sv
// add: 32-bit adder shared by the arithmetic datapath.
module add
    import arith_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential 32x32 unsigned shift-add multiplier with start/busy/done handshake.
module mul_seq
    import arith_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);
    mul_state_t        state_q, state_d;
    logic [WORD_W-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d, sum;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              carry, accept, zero;
    add u_add (.a(hi_q), .b(mcand_q), .sum(sum));
    // the adder has no carry-out, so recover it from wraparound
    assign carry   = sum < hi_q;
    assign accept  = start && state_q != RUN;
    assign zero    = ZERO_SKIP && (a == '0 || b == '0);
    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
    assign product = {hi_q, lo_q};
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        if (state_q == RUN) begin
            {hi_d, lo_d} = lo_q[0] ? {carry, sum, lo_q[WORD_W-1:1]} : {1'b0, hi_q, lo_q[WORD_W-1:1]};
            count_d      = count_q + 1'b1;
            state_d      = count_q == CNT_W'(MUL_ITER - 1) ? DONE : RUN;
        end else if (accept) begin
            mcand_d = a;
            hi_d    = '0;
            lo_d    = zero ? '0 : b;
            count_d = '0;
            state_d = zero ? DONE : RUN;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: vector table, handshake corner cases and random regression for mul_seq.
module tb_mul_seq;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          lat;
    } vec_t;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start0 = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, busy0, done0;
    logic [63:0] product, product0;
    int          n_chk = 0, n_pass = 0, n_done = 0;
    vec_t        v[7];
    mul_seq #(.ZERO_SKIP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );
    mul_seq #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(product0)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (done) n_done++;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask
    task automatic wait_done(inout int lat);
        while (!done && lat < 40) begin
            tick;
            lat++;
        end
    endtask
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit use0,
                          output int lat, output int bcnt, output logic [63:0] p);
        a = x;
        b = y;
        if (use0) start0 = 1'b1;
        else start = 1'b1;
        tick;
        start  = 1'b0;
        start0 = 1'b0;
        a      = $urandom;
        b      = $urandom;
        lat    = 1;
        bcnt   = 0;
        while (!(use0 ? done0 : done) && lat < 40) begin
            bcnt += int'(use0 ? busy0 : busy);
            tick;
            lat++;
        end
        p = use0 ? product0 : product;
    endtask
    initial begin
        int          lat, bcnt, nd;
        logic [63:0] p;
        logic [31:0] x, y;
        v[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F, 33};
        v[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33};
        v[2] = '{32'h0, 32'h1234_5678, 64'h0, 1};
        v[3] = '{32'h1234_5678, 32'h0, 64'h0, 1};
        v[4] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 33};
        v[5] = '{32'd7, 32'd9, 64'd63, 33};
        v[6] = '{32'hDEAD_BEEF, 32'h10, 64'h0000_000D_EADB_EEF0, 33};
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_product0", product0, 0);
        rst_n = 1'b1;
        tick;
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, 1'b0, lat, bcnt, p);
            chk($sformatf("vec%0d_latency", i), lat, v[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, v[i].lat - 1);
            chk($sformatf("vec%0d_product", i), p, v[i].p);
            tick;
            chk($sformatf("vec%0d_done_one_cycle", i), done, 0);
            chk($sformatf("vec%0d_product_held", i), product, v[i].p);
        end
        run_op(32'h0, 32'h1234_5678, 1'b1, lat, bcnt, p);
        chk("noskip_latency", lat, 33);
        chk("noskip_busy_cycles", bcnt, 32);
        chk("noskip_product", p, 0);
        tick;
        // start pulsed mid-run must be ignored; start in DONE is accepted
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        a     = 32'd2;
        b     = 32'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat   = 12;
        wait_done(lat);
        chk("ignore_latency", lat, 33);
        chk("ignore_product", product, 63);
        run_op(32'd2, 32'd2, 1'b0, lat, bcnt, p);
        chk("b2b_busy_cycles", bcnt, 32);
        chk("b2b_latency", lat, 33);
        chk("b2b_product", p, 4);
        tick;
        a     = 32'h8000_0000;
        b     = 32'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (16) tick;
        rst_n = 1'b0;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        rst_n = 1'b1;
        nd    = n_done;
        repeat (40) tick;
        chk("abort_no_done", n_done - nd, 0);
        run_op(32'h8000_0000, 32'd2, 1'b0, lat, bcnt, p);
        chk("after_abort_latency", lat, 33);
        chk("after_abort_product", p, 64'h0000_0001_0000_0000);
        tick;
        nd = n_done;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 15) == 0) x = '0;
            if ($urandom_range(0, 15) == 0) y = '0;
            run_op(x, y, 1'b0, lat, bcnt, p);
            chk($sformatf("rand%0d_product", i), p, 64'(x) * 64'(y));
            chk($sformatf("rand%0d_latency", i), lat, (x == 0 || y == 0) ? 1 : 33);
        end
        tick;
        chk("rand_done_count", n_done - nd, 1000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32x32 unsigned shift-add multiplier in the arithmetic part of the datapath, directly downstream of the existing 32-bit `add` block. The 32-bit partial-product additions go through one instance of `add`. Operands are accepted with a start/busy/done handshake, and a 64-bit product is produced after a fixed iteration count. The block feeds the ALU result mux and the HI/LO registers.

## Interface
- `ZERO_SKIP`, default 1: 1 = a zero operand finishes in one cycle with product 0; 0 = every operation runs all 32 iterations.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request; sampled only when `busy`=0.
- `a` in 32: multiplicand (unsigned), sampled with an accepted `start`.
- `b` in 32: multiplier (unsigned), sampled with an accepted `start`.
- `busy` out 1: operation in progress; `start` is ignored while high.
- `done` out 1: one-cycle pulse; `product` is valid from this cycle on.
- `product` out 64: {hi, lo} result; held until the next accepted `start`.

## Operation
- State machine states: IDLE, RUN, DONE.
- Registers:
  - `mcand[31:0]`
  - `acc_hi[31:0]`
  - `acc_lo[31:0]` (initially the multiplier; shifts out consumed bits)
  - `count[5:0]`
- IDLE/DONE with `start`=1 (accept):
  - `mcand`<=a; `acc_hi`<=0; `acc_lo`<=b; `count`<=0.
  - Next state RUN.
  - If ZERO_SKIP and (a==0 or b==0): `acc_hi`<=0, `acc_lo`<=0, next state DONE.
- RUN iteration, one per cycle:
  - `add` computes s = acc_hi + mcand (32-bit).
  - Carry c = (s < acc_hi), unsigned compare.
  - If acc_lo[0]=1: {acc_hi, acc_lo} <= {c, s, acc_lo[31:1]}.
  - Else: {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[31:1]}.
  - `count`<=count+1.
  - When count==31 during this iteration, next state DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or RUN/DONE if `start` is accepted.
- `product` = {acc_hi, acc_lo}, continuously driven from the registers.
- Product value is defined only from `done` until the next accept; intermediate values are visible while busy.
- `busy` = (state==RUN).
- `done` = (state==DONE).
- Results are exact modulo 2^64; no overflow is possible.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `busy`=0, `done`=0, `product`=0, `count`=0, `mcand`=0.
- Reset applied mid-operation aborts the operation with no `done` pulse.
- Accept at edge E0:
  - `busy`=1 after E0.
  - Iterations occur on edges E1..E32.
  - `done`=1 and `busy`=0 after E32, for one cycle.
  - Latency is 33 cycles from accept to `done`.
- Zero skip: `done`=1 after E0; `busy` stays 0; latency is 1 cycle.
- `start` while `busy`=1: ignored. No queuing, no effect on the running operation or its result.
- `start` during the DONE cycle: accepted. `busy`=1 on the next cycle, so back-to-back throughput is one result per 33 cycles.
- `start` held high continuously: a new operation begins at every IDLE/DONE opportunity.
- `a`/`b` need be stable only on the accept edge; changes while busy have no effect.

## Structure
- Shared package `arith_pkg`:
  - `WORD_W`=32
  - `PROD_W`=64
  - State typedef `mul_state_t` {IDLE, RUN, DONE}
  - `MUL_ITER`=32
- Sub-module: one instance of the existing `add` (32-bit a, b -> sum) for the partial-sum adder.
- Carry is recovered by comparison, not from `add`.
- No other sub-modules; control and shift register live in `mul_seq`.

## Test plan
- Reset then a=3, b=5, start for one cycle: `busy` for 32 cycles; then `done` pulse with product=64'h0000_0000_0000_000F.
- a=b=32'hFFFF_FFFF: product=64'hFFFF_FFFE_0000_0001, `done` exactly 33 cycles after accept; exercises the carry path.
- ZERO_SKIP=1, a=0, b=32'h1234_5678: `done` the cycle after accept, product=0, `busy` never high. With ZERO_SKIP=0, the same stimulus gives `done` at 33 cycles with product=0.
- During a running a=7, b=9 operation:
  - Pulse start with a=2, b=2 at iteration 10: ignored, product=63.
  - Then assert start with a=2, b=2 during the DONE cycle: accepted; next result 4.
- Drop `rst_n` at iteration 16 of a=32'h8000_0000, b=2: next cycle `busy`=0, `done`=0, product=0, and no `done` pulse follows. A subsequent start with the same operands yields 64'h0000_0001_0000_0000.
- Random regression: 1000 random a/b pairs, with random start gaps including back-to-back. Check product == a*b (64-bit) at each `done`, and exactly one `done` per accepted start.
